// File: rtl/fetch_hazard_controller.sv
// rtl/fetch_hazard_controller.sv - IF stage / IF-ID pipeline control with load-use, branch and imem-latency handling
// Tracks the outstanding fetch so that a wrong-path word returning after a redirect is discarded.
module fetch_hazard_controller #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             id_ex_mem_read,
    input  logic [4:0]       id_ex_rt,
    input  logic             ex_branch_taken,
    input  logic             imem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             imem_timeout,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_WAIT    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    localparam logic [15:0]      TMO_LIMIT = 16'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    state_t           state_q;
    state_t           state_d;
    logic             hazard;
    logic [15:0]      timer_q;
    logic             timeout_q;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    assign hazard = id_ex_mem_read && (id_ex_rt != 5'd0) &&
                    ((id_ex_rt == id_rs) || (id_uses_rt && (id_ex_rt == id_rt)));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // A hazard never moves the FSM: only fetch completion and redirects do.
    always_comb begin
        state_d = state_q;
        if (ex_branch_taken) begin
            state_d = imem_ready ? S_RUN : S_DISCARD;
        end else begin
            case (state_q)
                S_RUN, S_WAIT: state_d = imem_ready ? S_RUN : S_WAIT;
                S_DISCARD:     state_d = imem_ready ? S_RUN : S_DISCARD;
                default:       state_d = S_RUN;
            endcase
        end
    end

    always_comb begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        if (reset) begin
            if (ex_branch_taken) begin
                pc_write    = 1'b1;
                if_id_write = 1'b1;
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (state_q == S_DISCARD) begin
                // ID already holds a bubble, so a hazard cannot matter here.
                pc_write    = 1'b0;
                if_id_write = 1'b1;
                if_id_flush = 1'b1;
                id_ex_flush = 1'b0;
            end else begin
                pc_write    = imem_ready && !hazard;
                if_id_write = !hazard;
                if_id_flush = !hazard && !imem_ready;
                id_ex_flush = hazard;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            timer_q   <= 16'd0;
            timeout_q <= 1'b0;
            stall_q   <= '0;
            flush_q   <= '0;
        end else begin
            if (!pc_write && stall_q != CNT_MAX) begin
                stall_q <= stall_q + 1'b1;
            end
            if (ex_branch_taken && flush_q != CNT_MAX) begin
                flush_q <= flush_q + 1'b1;
            end
            if (timer_q == TMO_LIMIT) begin
                timeout_q <= 1'b1;
            end
            if (state_q != S_RUN && !imem_ready) begin
                if (timer_q != TMO_LIMIT) begin
                    timer_q <= timer_q + 16'd1;
                end
            end else begin
                timer_q <= 16'd0;
            end
        end
    end

    assign imem_timeout = timeout_q;
    assign stall_count  = stall_q;
    assign flush_count  = flush_q;

endmodule

// File: tb/tb_fetch_hazard_controller.sv
// tb/tb_fetch_hazard_controller.sv - randomized self-checking bench for fetch_hazard_controller
// Reference model tracks "fetch pending" and "wrong path" as plain flags.
module tb_fetch_hazard_controller;

    localparam int CNT_W   = 4;
    localparam int TIMEOUT = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic [4:0]       id_rs, id_rt, id_ex_rt;
    logic             id_uses_rt, id_ex_mem_read, ex_branch_taken, imem_ready;
    logic             pc_write, if_id_write, if_id_flush, id_ex_flush, imem_timeout;
    logic [CNT_W-1:0] stall_count, flush_count;

    int total = 0;
    int bad   = 0;

    // reference model state
    bit m_pending, m_wrong, m_to;
    int m_tmr, m_sc, m_fc;
    bit e_pc, e_ifw, e_iff, e_idf;

    fetch_hazard_controller #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_ex_mem_read(id_ex_mem_read), .id_ex_rt(id_ex_rt),
        .ex_branch_taken(ex_branch_taken), .imem_ready(imem_ready),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_flush(id_ex_flush), .imem_timeout(imem_timeout),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive, check combinational outputs, clock, check registered outputs.
    task automatic cycle(input bit rst_n, input bit br, input bit rdy, input bit mr,
                         input int ert, input int rs, input int rt, input bit urt);
        bit hz;
        reset = rst_n; ex_branch_taken = br; imem_ready = rdy; id_ex_mem_read = mr;
        id_ex_rt = 5'(ert); id_rs = 5'(rs); id_rt = 5'(rt); id_uses_rt = urt;
        hz = mr && ert != 0 && (ert == rs || (urt && ert == rt));
        #1;
        if (!rst_n)       begin e_pc = 0; e_ifw = 0; e_iff = 1; e_idf = 1; end
        else if (br)      begin e_pc = 1; e_ifw = 1; e_iff = 1; e_idf = 1; end
        else if (m_wrong) begin e_pc = 0; e_ifw = 1; e_iff = 1; e_idf = 0; end
        else begin
            e_pc = rdy && !hz; e_ifw = !hz; e_iff = !hz && !rdy; e_idf = hz;
        end
        check_eq("pc_write", int'(pc_write), int'(e_pc));
        check_eq("if_id_write", int'(if_id_write), int'(e_ifw));
        check_eq("if_id_flush", int'(if_id_flush), int'(e_iff));
        check_eq("id_ex_flush", int'(id_ex_flush), int'(e_idf));
        @(posedge clk);
        if (!rst_n) begin
            m_pending = 0; m_wrong = 0; m_to = 0; m_tmr = 0; m_sc = 0; m_fc = 0;
        end else begin
            if (!e_pc && m_sc < CNT_MAX) m_sc++;
            if (br && m_fc < CNT_MAX) m_fc++;
            if (m_tmr == TIMEOUT) m_to = 1;
            if (m_pending && !rdy) m_tmr = (m_tmr < TIMEOUT) ? m_tmr + 1 : TIMEOUT;
            else m_tmr = 0;
            if (br) begin
                m_pending = !rdy; m_wrong = !rdy;
            end else if (m_wrong) begin
                if (rdy) begin m_pending = 0; m_wrong = 0; end
            end else begin
                m_pending = !rdy;
            end
        end
        #1;
        check_eq("imem_timeout", int'(imem_timeout), int'(m_to));
        check_eq("stall_count", int'(stall_count), m_sc);
        check_eq("flush_count", int'(flush_count), m_fc);
        @(negedge clk);
    endtask

    task automatic plain(input bit rdy);
        cycle(1, 0, rdy, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int r_ert, r_rs, r_rt;
        m_pending = 0; m_wrong = 0; m_to = 0; m_tmr = 0; m_sc = 0; m_fc = 0;
        @(negedge clk);
        cycle(0, 0, 1, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 1, 8, 8, 0, 0);

        // load-use on rs, then zero-register load
        cycle(1, 0, 1, 1, 8, 8, 0, 0);
        plain(1);
        cycle(1, 0, 1, 1, 0, 0, 0, 0);
        // rt dependence gated by id_uses_rt
        cycle(1, 0, 1, 1, 9, 1, 9, 0);
        cycle(1, 0, 1, 1, 9, 1, 9, 1);
        // fetch wait of three cycles
        plain(0); plain(0); plain(0); plain(1);
        // branch while waiting, wrong-path word dropped
        plain(0);
        cycle(1, 1, 0, 0, 0, 0, 0, 0);
        plain(0); plain(0); plain(1); plain(1);
        // branch and hazard together
        cycle(1, 1, 1, 1, 8, 8, 0, 0);
        // timeout, sticky through ready, then reset
        for (int i = 0; i < 8; i++) plain(0);
        plain(1); plain(1);
        cycle(0, 0, 1, 0, 0, 0, 0, 0);
        plain(1);

        for (int n = 0; n < 3000; n++) begin
            r_ert = (($urandom_range(0, 3) == 0) ? 0 : $urandom_range(8, 10));
            r_rs  = $urandom_range(7, 10);
            r_rt  = $urandom_range(7, 10);
            cycle(($urandom_range(0, 60) != 0),
                  ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 3) != 0) ^ (n % 500 > 440 ? 1'b1 : 1'b0) ? (n % 500 <= 440) : 1'b0,
                  $urandom_range(0, 1) == 1, r_ert, r_rs, r_rt, $urandom_range(0, 1) == 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
